// File: rtl/block_dispatcher.sv
// Kernel-launch block dispatcher. It splits a launch's thread count into fixed-size blocks.
// It hands one block per cycle to a free core in round-robin order and tracks occupancy.

module block_dispatcher_slot (
    input  logic clk,
    input  logic reset,
    input  logic clr_en,
    input  logic grant,
    input  logic done_pulse,
    output logic active
);
    // A granted core is always idle, so grant and completion never collide on one slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                     active <= 1'b0;
        else if (grant)                active <= 1'b1;
        else if (clr_en && done_pulse) active <= 1'b0;
    end
endmodule

module block_dispatcher #(
    parameter int NUM_CORES         = 4,
    parameter int THREADS_PER_BLOCK = 4,
    parameter int TCNT_W            = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [TCNT_W-1:0]                     thread_count,
    output logic                                  busy,
    output logic                                  done,
    output logic [NUM_CORES-1:0]                  core_start,
    output logic [TCNT_W-1:0]                     core_block_id,
    output logic [$clog2(THREADS_PER_BLOCK):0]    core_threads,
    input  logic [NUM_CORES-1:0]                  core_done
);
    localparam int PTR_W = $clog2(NUM_CORES);
    localparam int SH    = $clog2(THREADS_PER_BLOCK);
    localparam int THR_W = SH + 1;
    localparam logic [TCNT_W-1:0] REM_MASK = TCNT_W'(THREADS_PER_BLOCK - 1);

    typedef enum logic [1:0] {IDLE, DISPATCH, WAIT, FINISH} state_t;

    state_t               state_q, state_d;
    logic [TCNT_W-1:0]    tcnt_q, tcnt_d;
    logic [TCNT_W:0]      total_q, total_d;
    logic [TCNT_W:0]      disp_q, disp_d, disp_inc;
    logic [PTR_W-1:0]     last_q, last_d;
    logic [PTR_W-1:0]     grant_idx, srch_idx;
    logic                 grant_vld;
    logic [NUM_CORES-1:0] active, grant_vec;
    logic                 busy_d, done_d;
    logic [NUM_CORES-1:0] cstart_d;
    logic [TCNT_W-1:0]    bid_d;
    logic [THR_W-1:0]     thr_d;
    logic [TCNT_W-1:0]    rem;
    logic                 last_blk;

    assign rem      = tcnt_q & REM_MASK;
    assign disp_inc = disp_q + 1'b1;
    assign last_blk = (disp_q == total_q - 1'b1);

    // Walk from the farthest candidate back to last+1 so the nearest free core wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        srch_idx  = '0;
        for (int k = NUM_CORES; k >= 1; k--) begin
            srch_idx = PTR_W'((int'(last_q) + k) % NUM_CORES);
            if (!active[srch_idx]) begin
                grant_vld = 1'b1;
                grant_idx = srch_idx;
            end
        end
    end

    assign grant_vec = (state_q == DISPATCH && grant_vld) ? (NUM_CORES'(1) << grant_idx) : '0;

    // The search above sees the occupancy mask before this cycle's completions land.
    for (genvar i = 0; i < NUM_CORES; i++) begin : g_slot
        block_dispatcher_slot u_slot (
            .clk        (clk),
            .reset      (reset),
            .clr_en     (state_q != IDLE),
            .grant      (grant_vec[i]),
            .done_pulse (core_done[i]),
            .active     (active[i])
        );
    end

    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        total_d  = total_q;
        disp_d   = disp_q;
        last_d   = last_q;
        busy_d   = busy;
        done_d   = 1'b0;
        cstart_d = '0;
        bid_d    = core_block_id;
        thr_d    = core_threads;
        case (state_q)
            IDLE: begin
                if (start) begin
                    tcnt_d  = thread_count;
                    total_d = ({1'b0, thread_count} + (TCNT_W+1)'(THREADS_PER_BLOCK - 1)) >> SH;
                    disp_d  = '0;
                    busy_d  = 1'b1;
                    state_d = (thread_count == '0) ? FINISH : DISPATCH;
                end
            end
            DISPATCH: begin
                if (grant_vld) begin
                    cstart_d = grant_vec;
                    bid_d    = disp_q[TCNT_W-1:0];
                    thr_d    = (last_blk && rem != '0) ? rem[THR_W-1:0] : THR_W'(THREADS_PER_BLOCK);
                    last_d   = grant_idx;
                    disp_d   = disp_inc;
                    if (disp_inc == total_q) state_d = WAIT;
                end
            end
            WAIT: begin
                if (active == '0) state_d = FINISH;
            end
            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            tcnt_q        <= '0;
            total_q       <= '0;
            disp_q        <= '0;
            last_q        <= PTR_W'(NUM_CORES - 1);
            busy          <= 1'b0;
            done          <= 1'b0;
            core_start    <= '0;
            core_block_id <= '0;
            core_threads  <= '0;
        end else begin
            state_q       <= state_d;
            tcnt_q        <= tcnt_d;
            total_q       <= total_d;
            disp_q        <= disp_d;
            last_q        <= last_d;
            busy          <= busy_d;
            done          <= done_d;
            core_start    <= cstart_d;
            core_block_id <= bid_d;
            core_threads  <= thr_d;
        end
    end
endmodule

// File: tb/tb_block_dispatcher.sv
// Self-checking bench for block_dispatcher: a launch-level reference model plus emulated cores.
`timescale 1ns/1ps
module tb_block_dispatcher;
    localparam int N = 4, TPB = 4, TW = 8;
    localparam int S_IDLE = 0, S_DISP = 1, S_WAIT = 2, S_FIN = 3;

    logic          clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [TW-1:0] thread_count = '0;
    logic          busy, done;
    logic [N-1:0]  core_start;
    logic [N-1:0]  core_done = '0;
    logic [TW-1:0] core_block_id;
    logic [2:0]    core_threads;

    int checks = 0, failures = 0;

    // reference model of the launch
    int m_st, m_cnt, m_total, m_disp, m_last, m_id, m_thr;
    bit m_busy, m_done;
    logic [N-1:0] m_cs;
    bit [N-1:0] m_act;

    // emulated cores
    int lat[N];
    bit auto_cores = 0, noise = 0;
    int lat_lo = 1, lat_hi = 1;

    block_dispatcher #(.NUM_CORES(N), .THREADS_PER_BLOCK(TPB), .TCNT_W(TW)) dut (
        .clk(clk), .reset(reset), .start(start), .thread_count(thread_count),
        .busy(busy), .done(done), .core_start(core_start), .core_block_id(core_block_id),
        .core_threads(core_threads), .core_done(core_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    function automatic void model_reset();
        m_st = S_IDLE; m_cnt = 0; m_total = 0; m_disp = 0; m_last = N - 1;
        m_id = 0; m_thr = 0; m_busy = 0; m_done = 0; m_cs = '0; m_act = '0;
        for (int c = 0; c < N; c++) lat[c] = 0;
    endfunction

    function automatic void model_step();
        bit [N-1:0] act0 = m_act;
        int st0 = m_st;
        int g = -1;
        m_done = 0;
        m_cs = '0;
        case (m_st)
            S_IDLE: if (start) begin
                m_cnt = int'(thread_count);
                m_total = (m_cnt + TPB - 1) / TPB;
                m_disp = 0;
                m_busy = 1;
                m_st = (m_cnt == 0) ? S_FIN : S_DISP;
            end
            S_DISP: begin
                for (int k = 1; k <= N; k++) begin
                    int c = (m_last + k) % N;
                    if (g < 0 && !act0[c]) g = c;
                end
                if (g >= 0) begin
                    m_cs[g] = 1'b1;
                    m_id = m_disp;
                    m_thr = (m_disp == m_total - 1 && (m_cnt % TPB) != 0) ? (m_cnt % TPB) : TPB;
                    m_last = g;
                    m_disp++;
                    if (m_disp == m_total) m_st = S_WAIT;
                end
            end
            S_WAIT: if (act0 == '0) m_st = S_FIN;
            default: begin m_done = 1; m_busy = 0; m_st = S_IDLE; end
        endcase
        if (st0 != S_IDLE) m_act = act0 & ~core_done;
        if (g >= 0) m_act[g] = 1'b1;
    endfunction

    function automatic void cores_update();
        core_done = '0;
        if (auto_cores) begin
            for (int c = 0; c < N; c++) if (m_cs[c]) lat[c] = $urandom_range(lat_hi, lat_lo);
            for (int c = 0; c < N; c++) if (lat[c] > 0) begin
                lat[c]--;
                if (lat[c] == 0) core_done[c] = 1'b1;
            end
            if (noise && $urandom_range(0, 9) == 0) core_done = core_done | N'($urandom);
        end
    endfunction

    function automatic logic [16:0] exp_vec();
        return {m_busy, m_done, m_cs, (m_cs != '0) ? 8'(m_id) : 8'h0, (m_cs != '0) ? 3'(m_thr) : 3'h0};
    endfunction

    function automatic logic [16:0] obs_vec();
        return {busy, done, core_start, (core_start != '0) ? core_block_id : 8'h0,
                (core_start != '0) ? core_threads : 3'h0};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        start = 1'b0;
        cores_update();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (core_start !== '0) begin failures++; $display("FAIL reset_core_start got=%b exp=0", core_start); end
        checks++; if (core_block_id !== '0) begin failures++; $display("FAIL reset_block_id got=%0d exp=0", core_block_id); end
        checks++; if (core_threads !== '0) begin failures++; $display("FAIL reset_threads got=%0d exp=0", core_threads); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [N-1:0] s_cs[$]; logic [TW-1:0] s_id[$]; logic [2:0] s_thr[$]; int s_cyc[$];
        int ndone = 0;
        bit fin = 0;
        auto_cores = 1; noise = 0; lat_lo = 3; lat_hi = 3;
        start = 1'b1; thread_count = 8'd16;
        for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin failures++; $display("FAIL basic cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
            if (core_start != '0) begin s_cs.push_back(core_start); s_id.push_back(core_block_id); s_thr.push_back(core_threads); s_cyc.push_back(cyc); end
            if (done) ndone++;
            fin = m_done;
        end
        checks++; if (!fin) begin failures++; $display("FAIL basic_timeout got=no_done exp=done"); end
        checks++; if (s_cs.size() != 4) begin failures++; $display("FAIL basic_count got=%0d exp=4", s_cs.size()); end
        for (int i = 0; i < s_cs.size() && i < 4; i++) begin
            checks++;
            if (s_cs[i] !== N'(1 << i) || s_id[i] !== TW'(i) || s_thr[i] !== 3'd4 || s_cyc[i] != i + 1)
                begin failures++; $display("FAIL basic_seq%0d got=%b/%0d/%0d@%0d exp=%b/%0d/4@%0d", i, s_cs[i], s_id[i], s_thr[i], s_cyc[i], N'(1 << i), i, i + 1); end
        end
        checks++; if (ndone != 1) begin failures++; $display("FAIL basic_done_pulses got=%0d exp=1", ndone); end
    endtask

    task automatic test_partial();
        logic [N-1:0] s_cs[$]; logic [TW-1:0] s_id[$]; logic [2:0] s_thr[$];
        int nblk = 0, last_thr = 0, last_id = 0;
        bit fin = 0;
        auto_cores = 0; noise = 0;
        start = 1'b1; thread_count = 8'd10;
        for (int cyc = 0; cyc < 8; cyc++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin failures++; $display("FAIL partial cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
            if (core_start != '0) begin s_cs.push_back(core_start); s_id.push_back(core_block_id); s_thr.push_back(core_threads); end
        end
        checks++; if (s_cs.size() != 3) begin failures++; $display("FAIL partial_count got=%0d exp=3", s_cs.size()); end
        for (int i = 0; i < s_cs.size() && i < 3; i++) begin
            checks++;
            if (s_cs[i] !== N'(1 << i) || s_id[i] !== TW'(i) || s_thr[i] !== ((i == 2) ? 3'd2 : 3'd4))
                begin failures++; $display("FAIL partial_blk%0d got=%b/%0d/%0d exp=%b/%0d/%0d", i, s_cs[i], s_id[i], s_thr[i], N'(1 << i), i, (i == 2) ? 2 : 4); end
        end
        core_done = 4'b0111;
        for (int cyc = 0; cyc < 20 && !fin; cyc++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin failures++; $display("FAIL partial_drain cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
            fin = m_done;
        end
        checks++; if (!fin) begin failures++; $display("FAIL partial_timeout got=no_done exp=done"); end
        fin = 0;
        auto_cores = 1; lat_lo = 1; lat_hi = 6;
        start = 1'b1; thread_count = 8'd255;
        for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin failures++; $display("FAIL max_count cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
            if (core_start != '0) begin nblk++; last_thr = int'(core_threads); last_id = int'(core_block_id); end
            fin = m_done;
        end
        checks++; if (!fin) begin failures++; $display("FAIL max_timeout got=no_done exp=done"); end
        checks++; if (nblk != 64) begin failures++; $display("FAIL max_blocks got=%0d exp=64", nblk); end
        checks++; if (last_thr != 3 || last_id != 63) begin failures++; $display("FAIL max_last got=id%0d/%0d exp=id63/3", last_id, last_thr); end
    endtask

    task automatic test_back_pressure();
        bit fin = 0;
        auto_cores = 0; noise = 0;
        start = 1'b1; thread_count = 8'd24;
        for (int cyc = 0; cyc < 8; cyc++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin failures++; $display("FAIL bp_fill cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
            if (cyc >= 5) begin
                checks++;
                if (core_start !== '0) begin failures++; $display("FAIL bp_stall cyc=%0d got=%b exp=0000", cyc, core_start); end
            end
        end
        core_done = 4'b0100;
        tick();
        checks++; if (core_start !== '0) begin failures++; $display("FAIL bp_free_cycle got=%b exp=0000", core_start); end
        tick();
        checks++; if (core_start !== 4'b0100 || core_block_id !== 8'd4) begin failures++; $display("FAIL bp_redispatch got=%b/%0d exp=0100/4", core_start, core_block_id); end
        core_done = 4'b0001;
        tick();
        checks++; if (obs_vec() !== exp_vec()) begin failures++; $display("FAIL bp_c0_free got=%h exp=%h", obs_vec(), exp_vec()); end
        core_done = 4'b1000;
        tick();
        checks++; if (core_start !== 4'b0001 || core_block_id !== 8'd5) begin failures++; $display("FAIL bp_same_cycle got=%b/%0d exp=0001/5", core_start, core_block_id); end
        core_done = 4'b0111;
        for (int cyc = 0; cyc < 20 && !fin; cyc++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin failures++; $display("FAIL bp_drain cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
            fin = m_done;
        end
        checks++; if (!fin) begin failures++; $display("FAIL bp_timeout got=no_done exp=done"); end
    endtask

    task automatic test_zero_count();
        auto_cores = 0; noise = 0;
        start = 1'b1; thread_count = 8'd0;
        tick();
        checks++; if (busy !== 1'b1 || done !== 1'b0 || core_start !== '0) begin failures++; $display("FAIL zero_edge1 got=b%b d%b cs%b exp=b1 d0 cs0000", busy, done, core_start); end
        tick();
        checks++; if (busy !== 1'b0 || done !== 1'b1 || core_start !== '0) begin failures++; $display("FAIL zero_edge2 got=b%b d%b cs%b exp=b0 d1 cs0000", busy, done, core_start); end
        tick();
        checks++; if (done !== 1'b0 || core_start !== '0) begin failures++; $display("FAIL zero_edge3 got=d%b cs%b exp=d0 cs0000", done, core_start); end
    endtask

    task automatic test_ignored();
        int nblk = 0, idle_c = 0;
        bit fin = 0;
        auto_cores = 0; noise = 0;
        start = 1'b1; thread_count = 8'd12;
        tick();
        start = 1'b1; thread_count = 8'd4;
        for (int cyc = 0; cyc < 6; cyc++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin failures++; $display("FAIL ign_start cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
            if (core_start != '0) nblk++;
        end
        checks++; if (nblk != 3) begin failures++; $display("FAIL ign_total got=%0d exp=3", nblk); end
        for (int c = N - 1; c >= 0; c--) if (!m_act[c]) idle_c = c;
        core_done = N'(1 << idle_c);
        for (int cyc = 0; cyc < 4; cyc++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL ign_spurious cyc=%0d got=d%b b%b exp=d0 b1", cyc, done, busy); end
        end
        core_done = m_act;
        for (int cyc = 0; cyc < 20 && !fin; cyc++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin failures++; $display("FAIL ign_drain cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
            fin = m_done;
        end
        checks++; if (!fin) begin failures++; $display("FAIL ign_timeout got=no_done exp=done"); end
    endtask

    task automatic test_reset_mid();
        bit fin = 0;
        auto_cores = 0; noise = 0;
        start = 1'b1; thread_count = 8'd24;
        repeat (3) tick();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        checks++; if (obs_vec() !== 17'h0 || core_block_id !== '0 || core_threads !== '0) begin failures++; $display("FAIL rst_mid_outputs got=%h/%0d/%0d exp=0", obs_vec(), core_block_id, core_threads); end
        @(negedge clk);
        reset = 1'b0;
        core_done = 4'b0011;
        tick();
        checks++; if (obs_vec() !== exp_vec()) begin failures++; $display("FAIL rst_late_done got=%h exp=%h", obs_vec(), exp_vec()); end
        start = 1'b1; thread_count = 8'd4;
        tick(); tick();
        checks++; if (core_start !== 4'b0001 || core_threads !== 3'd4) begin failures++; $display("FAIL rst_first_core got=%b/%0d exp=0001/4", core_start, core_threads); end
        core_done = 4'b0001;
        for (int cyc = 0; cyc < 20 && !fin; cyc++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin failures++; $display("FAIL rst_drain cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
            fin = m_done;
        end
        checks++; if (!fin) begin failures++; $display("FAIL rst_timeout got=no_done exp=done"); end
        start = 1'b1; thread_count = 8'd4;
        tick(); tick();
        checks++; if (core_start !== 4'b0010) begin failures++; $display("FAIL rr_persist got=%b exp=0010", core_start); end
        auto_cores = 1; lat_lo = 1; lat_hi = 1;
        lat[1] = 1;
        fin = 0;
        for (int cyc = 0; cyc < 20 && !fin; cyc++) begin
            tick();
            fin = m_done;
        end
        checks++; if (!fin || done !== 1'b1) begin failures++; $display("FAIL rr_drain got=d%b exp=d1", done); end
    endtask

    task automatic test_random();
        auto_cores = 1; noise = 1; lat_lo = 1; lat_hi = 8;
        for (int l = 0; l < 12; l++) begin
            bit fin;
            fin = 0;
            start = 1'b1;
            thread_count = ($urandom_range(0, 1) != 0) ? TW'($urandom_range(0, 24)) : TW'($urandom_range(0, 255));
            for (int cyc = 0; cyc < 1500 && !fin; cyc++) begin
                tick();
                checks++;
                if (obs_vec() !== exp_vec()) begin failures++; $display("FAIL rand l=%0d cyc=%0d got=%h exp=%h", l, cyc, obs_vec(), exp_vec()); end
                fin = m_done;
                if ($urandom_range(0, 15) == 0) begin start = 1'b1; thread_count = TW'($urandom); end
            end
            checks++; if (!fin) begin failures++; $display("FAIL rand_timeout l=%0d got=no_done exp=done", l); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_back_pressure();
        test_zero_count();
        test_ignored();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
